// File: rtl/dds_voice_engine.sv
// Multi-channel DDS tone generator with a built-in sample sequencer and saturating mixer.
// Optional noise waveforms (codes 4-7) are enabled by defining DDS_NOISE_EN.
module dds_voice_engine #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned VOL_W      = 8,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SAMPLE_DIV = 1024
) (
    input  logic                       clk_in,
    input  logic                       reset_n_in,
    input  logic                       wr_en_in,
    input  logic [$clog2(NUM_CH)+1:0]  addr_in,
    input  logic [PHASE_W-1:0]         data_in,
    output logic [OUT_W-1:0]           sample_out,
    output logic                       sample_valid_out,
    input  logic                       sample_ready_in,
    output logic                       overrun_out,
    output logic                       busy_out
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam int unsigned SHIFT = OUT_W - 1 - VOL_W;

    typedef enum logic [1:0] {S_IDLE, S_PHASE, S_MIX, S_LOAD} state_t;
    state_t state, state_nxt;

    logic [PHASE_W-1:0] incr [NUM_CH];
    logic [PHASE_W-1:0] acc  [NUM_CH];
    logic [VOL_W-1:0]   vol  [NUM_CH];
    logic [2:0]         wave [NUM_CH];
    logic [NUM_CH-1:0]  en, bits;
    logic               run;
    logic [DIV_W-1:0]   div;
    logic [CH_W-1:0]    idx;
    logic signed [OUT_W-1:0] mix, mix_base, mix_sat;
    logic signed [OUT_W:0]   amp, contrib, sum;
    logic [PHASE_W-1:0] acc_new;
    logic               bit_new, last_ch, clr_ovr, clr_acc;
    logic [1:0]         field;
    logic [CH_W-1:0]    wch;

    assign field   = addr_in[CH_W+1:CH_W];
    assign wch     = addr_in[CH_W-1:0];
    assign clr_ovr = wr_en_in && field == 2'd3 && data_in[1];
    assign clr_acc = wr_en_in && field == 2'd3 && data_in[2];
    assign last_ch = idx == CH_W'(NUM_CH - 1);

    function automatic logic wave_lut(input logic [2:0] p, input logic [1:0] w);
        case (w)
            2'd1:    return p == 3'd7;
            2'd2:    return p >= 3'd6;
            2'd3:    return p >= 3'd5;
            default: return p[2];
        endcase
    endfunction

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                incr[i] <= '0;
                vol[i]  <= '0;
                wave[i] <= '0;
            end
            en  <= '0;
            run <= 1'b0;
        end else if (wr_en_in) begin
            case (field)
                2'd0: incr[wch] <= data_in;
                2'd1: vol[wch]  <= data_in[VOL_W-1:0];
                2'd2: begin
                    wave[wch] <= data_in[2:0];
                    en[wch]   <= data_in[3];
                end
                default: run <= data_in[0];
            endcase
        end
    end

`ifdef DDS_NOISE_EN
    logic        carry, lfsr_step;
    logic [14:0] lfsr, lfsr_nxt;
    assign {carry, acc_new} = {1'b0, acc[idx]} + {1'b0, incr[idx]};
    assign lfsr_nxt  = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    assign lfsr_step = state == S_PHASE && wave[idx][2] && carry;
    assign bit_new   = wave[idx][2] ? (lfsr_step ? lfsr_nxt[0] : lfsr[0])
                                    : wave_lut(acc_new[PHASE_W-1 -: 3], wave[idx][1:0]);
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in)    lfsr <= 15'h0001;
        else if (lfsr_step) lfsr <= lfsr_nxt;
    end
`else
    assign acc_new = acc[idx] + incr[idx];
    assign bit_new = wave_lut(acc_new[PHASE_W-1 -: 3], wave[idx][2] ? 2'd0 : wave[idx][1:0]);
`endif

    // One guard bit is enough: each step adds at most one amp, which fits in OUT_W-1 bits.
    always_comb begin
        mix_base = (idx == '0) ? '0 : mix;
        amp      = (OUT_W+1)'(vol[idx]) << SHIFT;
        if (!en[idx])      contrib = '0;
        else if (bits[idx]) contrib = amp;
        else                contrib = -amp;
        sum = {mix_base[OUT_W-1], mix_base} + contrib;
        if (sum[OUT_W] != sum[OUT_W-1])
            mix_sat = sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
            mix_sat = sum[OUT_W-1:0];
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run && div == '0) state_nxt = S_PHASE;
            S_PHASE: if (last_ch) state_nxt = S_MIX;
            S_MIX:   if (last_ch) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out = state != S_IDLE;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
            bits             <= '0;
            mix              <= '0;
            div              <= '0;
            idx              <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            if (!run)                              div <= '0;
            else if (div == DIV_W'(SAMPLE_DIV - 1)) div <= '0;
            else                                   div <= div + 1'b1;

            if (state != state_nxt)                       idx <= '0;
            else if (state == S_PHASE || state == S_MIX) idx <= idx + 1'b1;

            if (clr_acc)
                for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
            else if (state == S_PHASE)
                acc[idx] <= acc_new;

            if (state == S_PHASE) bits[idx] <= bit_new;
            if (state == S_MIX)   mix <= mix_sat;

            if (state == S_LOAD) begin
                sample_out       <= mix;
                sample_valid_out <= 1'b1;
            end else if (sample_valid_out && sample_ready_in) begin
                sample_valid_out <= 1'b0;
            end

            if (clr_ovr)
                overrun_out <= 1'b0;
            else if (state == S_LOAD && sample_valid_out && !sample_ready_in)
                overrun_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dds_voice_engine.sv
// Directed plus randomized checks of dds_voice_engine (default parameters, noise disabled)
// against an arithmetic model of phase accumulation, wave shaping and saturating mixing.
module tb_dds_voice_engine;
    logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, ready = 1'b1;
    logic [3:0]  addr = '0;
    logic [15:0] data = '0;
    logic [15:0] sample;
    logic        valid, overrun, busy;

    dds_voice_engine #(.NUM_CH(4), .PHASE_W(16), .VOL_W(8), .OUT_W(16), .SAMPLE_DIV(1024)) dut (
        .clk_in(clk), .reset_n_in(rst_n), .wr_en_in(wr_en), .addr_in(addr), .data_in(data),
        .sample_out(sample), .sample_valid_out(valid), .sample_ready_in(ready),
        .overrun_out(overrun), .busy_out(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int incr_m[4], vol_m[4], wave_m[4], en_m[4], acc_m[4];
    logic [15:0] s, e2, e3;
    int tv, tb, tv0, cnt;
    bit ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negedge; the write lands on the following posedge.
    task automatic wr(input int f, input int ch, input int d);
        addr  = {2'(f), 2'(ch)};
        data  = 16'(d);
        wr_en = 1'b1;
        case (f)
            0: incr_m[ch] = d & 16'hFFFF;
            1: vol_m[ch]  = d & 8'hFF;
            2: begin wave_m[ch] = d & 7; en_m[ch] = (d >> 3) & 1; end
            default: if (d & 4) for (int i = 0; i < 4; i++) acc_m[i] = 0;
        endcase
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    function automatic logic [15:0] model_step();
        int mix = 0;
        for (int ch = 0; ch < 4; ch++) begin
            int p, w, amp;
            bit hi;
            acc_m[ch] = (acc_m[ch] + incr_m[ch]) % 65536;
            p = acc_m[ch] / 8192;
            w = (wave_m[ch] > 3) ? 0 : wave_m[ch];
            hi = (w == 0) ? (p >= 4) : (w == 1) ? (p == 7) : (w == 2) ? (p >= 6) : (p >= 5);
            amp = vol_m[ch] * 128;
            if (en_m[ch] != 0) mix += hi ? amp : -amp;
            if (mix > 32767)  mix = 32767;
            if (mix < -32768) mix = -32768;
        end
        return 16'(mix);
    endfunction

    task automatic get_sample(output logic [15:0] so, output int tvo, output int tbo, output bit oko);
        tbo = -1; tvo = -1; oko = 1'b0; so = '0;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            if (busy && tbo < 0) tbo = cyc;
            if (valid) begin so = sample; tvo = cyc; oko = 1'b1; break; end
        end
    endtask

    task automatic next_sample(input string tag, output logic [15:0] so, output int tvo, output int tbo);
        bit oko;
        get_sample(so, tvo, tbo, oko);
        chk({tag, "_arrived"}, 32'(oko), 32'd1);
        chk(tag, so, model_step());
    endtask

    task automatic wait_busy(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2200 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        chk({tag, "_busy_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic stop_and_clear();
        ready = 1'b1;
        wr(3, 0, 0);
        repeat (40) @(negedge clk);
        wr(3, 0, 6);
        for (int ch = 0; ch < 4; ch++) wr(2, ch, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            incr_m[i] = 0; vol_m[i] = 0; wave_m[i] = 0; en_m[i] = 0; acc_m[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sample", sample, 16'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Single square channel: three negative half-levels, then positive; latency and period.
        wr(0, 0, 'h2000); wr(1, 0, 'hFF); wr(2, 0, 8); wr(3, 0, 1);
        next_sample("sq1", s, tv, tb);
        chk("sq1_const", s, 16'h8080);
        chk("latency", 32'(tv - tb), 32'd9);
        tv0 = tv;
        next_sample("sq2", s, tv, tb);
        chk("period", 32'(tv - tv0), 32'd1024);
        next_sample("sq3", s, tv, tb);
        chk("sq3_const", s, 16'h8080);
        next_sample("sq4", s, tv, tb);
        chk("sq4_const", s, 16'h7F80);
        stop_and_clear();

        // Four full-volume channels in phase: saturate at both rails.
        for (int ch = 0; ch < 4; ch++) begin wr(0, ch, 'h8000); wr(1, ch, 'hFF); wr(2, ch, 8); end
        wr(3, 0, 1);
        next_sample("sat1", s, tv, tb);
        chk("sat1_const", s, 16'h7FFF);
        next_sample("sat2", s, tv, tb);
        chk("sat2_const", s, 16'h8000);
        next_sample("sat3", s, tv, tb);
        next_sample("sat4", s, tv, tb);
        stop_and_clear();

        // Pulse widths: wave 1 high on 1 of 8 phases, wave 3 on 3 of 8.
        for (int w = 1; w <= 3; w += 2) begin
            wr(0, 0, 'h2000); wr(1, 0, 'hFF); wr(2, 0, 8 | w); wr(3, 0, 1);
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                next_sample("pulse", s, tv, tb);
                if (s[15] == 1'b0) cnt++;
            end
            chk("pulse_high_count", 32'(cnt), 32'((w == 1) ? 1 : 3));
            stop_and_clear();
        end

        // Randomized channel configurations.
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 4; ch++) begin
                wr(0, ch, int'($urandom_range(0, 65535)));
                wr(1, ch, int'($urandom_range(0, 255)));
                wr(2, ch, int'($urandom_range(0, 15)));
            end
            wr(3, 0, 1);
            for (int k = 0; k < 4; k++) next_sample("rand", s, tv, tb);
            stop_and_clear();
        end

        // Backpressure: overrun on an unaccepted LOAD, none when ready coincides with LOAD.
        wr(0, 0, 'h2000); wr(1, 0, 'h40); wr(2, 0, 8);
        ready = 1'b0;
        wr(3, 0, 1);
        next_sample("bp1", s, tv, tb);
        wait_busy("bp2");
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        e2 = model_step();
        chk("bp2_valid", valid, 1'b1);
        chk("bp2_sample", sample, e2);
        chk("bp2_overrun", overrun, 1'b1);
        wr(3, 0, 3);
        chk("ovr_cleared", overrun, 1'b0);
        chk("bp2_hold_valid", valid, 1'b1);
        chk("bp2_hold_sample", sample, e2);
        wait_busy("bp3");
        e3 = model_step();
        repeat (8) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        chk("bp3_overrun", overrun, 1'b0);
        chk("bp3_valid", valid, 1'b1);
        chk("bp3_sample", sample, e3);
        @(negedge clk);
        chk("bp3_taken", valid, 1'b0);
        stop_and_clear();

        // Clearing run during PHASE: the sample in flight still arrives, then nothing more.
        wr(0, 0, 'h2000); wr(1, 0, 'hFF); wr(2, 0, 8); wr(3, 0, 1);
        wait_busy("stop");
        wr(3, 0, 0);
        next_sample("stop_last", s, tv, tb);
        cnt = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (busy || valid) cnt++;
        end
        chk("stop_quiet", 32'(cnt), 32'd0);

        // Reset during MIX: everything returns to zero and stays idle.
        wr(3, 0, 1);
        wait_busy("rst");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_sample", sample, 16'h0);
        chk("mrst_valid", valid, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (busy || valid) cnt++;
        end
        chk("mrst_quiet", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
